riscv_memory: RTL and testbench
===============================

// Module: riscv_memory
// PURPOSE
//  Memory responder on the far side of the riscv_hart instruction and data ports.
//  Serves instruction fetch (pc -> instruction) and data load/store (mem_addr/mem_data/mem_write -> mem_read).
//  After reset a loader FSM fills memory from a byte stream and holds the hart in reset until loading completes.
//  Flags misaligned, out-of-range and overflow accesses.
// PARAMETERS
//  XLEN           32    data/address width, matches the hart
//  DEPTH          1024  number of 32-bit words; power of two; AW = $clog2(DEPTH)
//  LOAD_ON_RESET  1     1: enter LOAD after reset; 0: enter RUN directly (loader unused)
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     asynchronous, active-high reset
//  pc         in   XLEN  instruction fetch byte address
//  instruction out 32    fetched instruction word
//  mem_addr   in   XLEN  data byte address
//  mem_data   in   XLEN  store data
//  mem_write  in   1     store strobe, one word per cycle
//  mem_read   out  XLEN  load data
//  ld_valid   in   1     loader byte valid
//  ld_data    in   8     loader byte
//  ld_last    in   1     qualifies final byte of the image
//  ld_ready   out  1     loader accepts bytes; high only in LOAD
//  hart_rst   out  1     reset to hart; high while not in RUN
//  fault      out  1     sticky error flag
// BEHAVIOUR
//  Storage: word array mem[DEPTH]; word index = addr[AW+1:2]; addr in range iff addr[XLEN-1:AW+2]==0.
//  Reads are combinational, zero latency: the hart samples mem_read in the same cycle mem_addr is presented.
//   instruction = in-range pc ? mem[pc idx] : 32'h00000013 (NOP).
//   mem_read = in-range mem_addr ? mem[idx] : 0.
//   addr[1:0] is ignored on reads; no fault is raised on reads.
//  Writes take effect on the clk rising edge.
//   A read of the same word in the write cycle returns the old data; the new data is visible next cycle.
//  Store accepted iff state==RUN & mem_write & mem_addr[1:0]==0 & in range.
//   Misaligned or out-of-range store: memory unchanged; fault<=1.
//   Stores in LOAD are ignored with no fault.
//  FSM states LOAD, RUN.
//   rst -> LOAD if LOAD_ON_RESET, else RUN.
//   LOAD: ld_ready=1. Each ld_valid&ld_ready byte is placed in lane byte_cnt (little-endian) of the assembly word, then byte_cnt++.
//   On byte_cnt==3 the word is written to mem[ld_ptr]; ld_ptr++; byte_cnt=0; the assembly word is cleared.
//   ld_last with a byte: the word is written with unfilled upper lanes = 0 (even if partial); next state RUN.
//   Overflow: a byte arriving when ld_ptr==DEPTH is dropped, fault<=1, next state RUN.
//   ld_valid low: no change. RUN is terminal until rst.
//  hart_rst is registered: 1 during reset and in LOAD; 0 from the cycle after RUN is entered.
//   With LOAD_ON_RESET=0, hart_rst is 0 from the first clk edge after rst falls.
//  Reset values: hart_rst=1, fault=0, ld_ptr=0, byte_cnt=0, assembly word=0.
//   ld_ready=LOAD_ON_RESET, since it is decoded from state.
//   Memory contents are NOT cleared by rst.
//  Reset mid-load: ld_ptr and byte_cnt return to 0; words already written persist; a partial word is discarded.
//  fault clears only on rst.
// TESTING
//  Load bytes 13 00 00 00 93 00 10 00 with ld_last on byte 8
//   -> mem[0]=00000013, mem[1]=00100093; hart_rst falls 1 cycle after last; pc=4 -> instruction=00100093.
//  Load AA BB CC with ld_last on CC -> mem[0]=00CCBBAA; ld_ready low next cycle.
//  RUN: mem_write=1, addr 0x10, data DEADBEEF
//   -> same-cycle mem_read=old value; next cycle, addr 0x10 -> mem_read=DEADBEEF.
//  Store addr 0x11 -> mem unchanged, fault=1 next cycle and stays 1; addr 1<<(AW+2) store -> fault, no write.
//  pc out of range -> instruction=00000013; mem_addr out of range -> mem_read=0.
//  DEPTH=4: stream 17 bytes -> bytes 1-16 fill mem; byte 17 dropped; fault=1; RUN.
//   Reset asserted after 6 bytes, then reload -> ld_ptr restarts at 0.

Source files
------------

// File: rtl/riscv_memory_if.sv
// Bus between riscv_memory and its clients: hart fetch/data ports, byte loader, and status.
// The master side is the hart/loader; the slave side is the memory.
interface riscv_memory_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] pc;
    logic [31:0]     instruction;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            mem_write;
    logic [XLEN-1:0] mem_read;
    logic            ld_valid;
    logic [7:0]      ld_data;
    logic            ld_last;
    logic            ld_ready;
    logic            hart_rst;
    logic            fault;

    modport master (
        output pc, mem_addr, mem_data, mem_write, ld_valid, ld_data, ld_last,
        input  instruction, mem_read, ld_ready, hart_rst, fault
    );

    modport slave (
        input  pc, mem_addr, mem_data, mem_write, ld_valid, ld_data, ld_last,
        output instruction, mem_read, ld_ready, hart_rst, fault
    );
endinterface

// File: rtl/riscv_memory.sv
// Word-addressed instruction/data memory with a byte-stream loader that holds the hart in
// reset until the image is in place. Reads are combinational; writes land on the clock edge.
module riscv_memory #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned DEPTH         = 1024,
    parameter bit          LOAD_ON_RESET = 1'b1
) (
    input logic           clk,
    input logic           rst,
    riscv_memory_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrFull = (AW + 1)'(DEPTH);

    typedef enum logic [0:0] {StLoad, StRun} state_e;

    state_e          state_q, state_d;
    logic [AW:0]     ld_ptr_q, ld_ptr_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [31:0]     asm_q, asm_d;
    logic            fault_q, fault_d;
    logic            hart_rst_q;

    logic [XLEN-1:0] mem [DEPTH];
    logic [31:0]     ld_word;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;

    logic            pc_ok, addr_ok, store_ok, ld_full;
    logic [AW-1:0]   pc_idx, addr_idx;
    logic            unused_pc_lsb;

    assign pc_ok    = (bus.pc[XLEN-1:AW+2] == '0);
    assign addr_ok  = (bus.mem_addr[XLEN-1:AW+2] == '0);
    assign pc_idx   = bus.pc[AW+1:2];
    assign addr_idx = bus.mem_addr[AW+1:2];
    assign store_ok = addr_ok && (bus.mem_addr[1:0] == 2'b00);
    assign ld_full  = (ld_ptr_q == PtrFull);
    assign unused_pc_lsb = ^bus.pc[1:0];

    always_comb begin
        ld_word = asm_q;
        ld_word[8*byte_cnt_q +: 8] = bus.ld_data;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD_ON_RESET ? StLoad : StRun;
            ld_ptr_q   <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            fault_q    <= 1'b0;
            hart_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            ld_ptr_q   <= ld_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            fault_q    <= fault_d;
            hart_rst_q <= (state_q != StRun);
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        ld_ptr_d   = ld_ptr_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        fault_d    = fault_q;
        unique case (state_q)
            StLoad: begin
                if (bus.ld_valid) begin
                    if (ld_full) begin
                        fault_d = 1'b1;
                        state_d = StRun;
                    end else begin
                        if (byte_cnt_q == 2'd3 || bus.ld_last) begin
                            ld_ptr_d   = ld_ptr_q + 1'b1;
                            byte_cnt_d = '0;
                            asm_d      = '0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                            asm_d      = ld_word;
                        end
                        if (bus.ld_last) state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (bus.mem_write && !store_ok) fault_d = 1'b1;
            end
            default: state_d = state_q;
        endcase
    end

    // Outputs and the single memory write port (loader and stores never overlap)
    always_comb begin
        we    = 1'b0;
        waddr = ld_ptr_q[AW-1:0];
        wdata = XLEN'(ld_word);
        unique case (state_q)
            StLoad: begin
                we = bus.ld_valid && !ld_full && (byte_cnt_q == 2'd3 || bus.ld_last);
            end
            StRun: begin
                if (bus.mem_write && store_ok) begin
                    we    = 1'b1;
                    waddr = addr_idx;
                    wdata = bus.mem_data;
                end
            end
            default: we = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign bus.instruction = pc_ok ? mem[pc_idx][31:0] : 32'h0000_0013;
    assign bus.mem_read    = addr_ok ? mem[addr_idx] : '0;
    assign bus.ld_ready    = (state_q == StLoad);
    assign bus.hart_rst    = hart_rst_q;
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_riscv_memory.sv
// Directed bench: loader sequences, a vector table of run-time reads/stores, overflow and
// mid-load reset on a 4-word instance, and the no-loader configuration.
module tb_riscv_memory;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst4, rst0;

    riscv_memory_if #(.XLEN(32)) bus  ();
    riscv_memory_if #(.XLEN(32)) bus4 ();
    riscv_memory_if #(.XLEN(32)) bus0 ();

    riscv_memory #(.XLEN(32), .DEPTH(1024), .LOAD_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    riscv_memory #(.XLEN(32), .DEPTH(4), .LOAD_ON_RESET(1'b1)) dut4 (
        .clk(clk), .rst(rst4), .bus(bus4)
    );
    riscv_memory #(.XLEN(32), .DEPTH(16), .LOAD_ON_RESET(1'b0)) dut0 (
        .clk(clk), .rst(rst0), .bus(bus0)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
        logic        chk_rd;
        logic [31:0] exp_instr;
        logic [31:0] exp_rd;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int which, input logic [7:0] d, input logic last);
        case (which)
            0: begin bus.ld_valid = 1'b1;  bus.ld_data = d;  bus.ld_last = last;  end
            4: begin bus4.ld_valid = 1'b1; bus4.ld_data = d; bus4.ld_last = last; end
            default: begin bus0.ld_valid = 1'b1; bus0.ld_data = d; bus0.ld_last = last; end
        endcase
        tick();
        bus.ld_valid = 1'b0;  bus.ld_last = 1'b0;
        bus4.ld_valid = 1'b0; bus4.ld_last = 1'b0;
        bus0.ld_valid = 1'b0; bus0.ld_last = 1'b0;
    endtask

    logic [7:0] img[8];

    initial begin
        // pc, addr, data, wr, chk_rd, exp_instr, exp_rd, exp_fault
        vecs[0]  = '{32'h0,    32'h10,   32'h1111_1111, 1, 0, 32'h00CC_BBAA, 32'h0,         0};
        vecs[1]  = '{32'h4,    32'h10,   32'hDEAD_BEEF, 1, 1, 32'h0010_0093, 32'h1111_1111, 0};
        vecs[2]  = '{32'h10,   32'h10,   32'h0,         0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0};
        vecs[3]  = '{32'h4000, 32'h1000, 32'h0,         0, 1, 32'h0000_0013, 32'h0,         0};
        vecs[4]  = '{32'h0,    32'h12,   32'h0,         0, 1, 32'h00CC_BBAA, 32'hDEAD_BEEF, 0};
        vecs[5]  = '{32'h0,    32'h11,   32'h1234_5678, 1, 1, 32'h00CC_BBAA, 32'hDEAD_BEEF, 0};
        vecs[6]  = '{32'h10,   32'h10,   32'h0,         0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
        vecs[7]  = '{32'h0,    32'h1000, 32'hCAFE_F00D, 1, 1, 32'h00CC_BBAA, 32'h0,         1};
        vecs[8]  = '{32'h4,    32'h0,    32'h0,         0, 1, 32'h0010_0093, 32'h00CC_BBAA, 1};
        vecs[9]  = '{32'h0,    32'h14,   32'h0000_A5A5, 1, 0, 32'h00CC_BBAA, 32'h0,         1};
        vecs[10] = '{32'h14,   32'h14,   32'h0,         0, 1, 32'h0000_A5A5, 32'h0000_A5A5, 1};
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

        bus.pc = '0;  bus.mem_addr = '0;  bus.mem_data = '0;  bus.mem_write = 0;
        bus.ld_valid = 0;  bus.ld_data = '0;  bus.ld_last = 0;
        bus4.pc = '0; bus4.mem_addr = '0; bus4.mem_data = '0; bus4.mem_write = 0;
        bus4.ld_valid = 0; bus4.ld_data = '0; bus4.ld_last = 0;
        bus0.pc = '0; bus0.mem_addr = '0; bus0.mem_data = '0; bus0.mem_write = 0;
        bus0.ld_valid = 0; bus0.ld_data = '0; bus0.ld_last = 0;

        rst = 1; rst4 = 1; rst0 = 1;
        repeat (2) tick();
        check("rst_hart_rst", 32'(bus.hart_rst), 32'd1);
        check("rst_fault", 32'(bus.fault), 32'd0);
        check("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("rst0_ld_ready", 32'(bus0.ld_ready), 32'd0);
        check("rst0_hart_rst", 32'(bus0.hart_rst), 32'd1);
        rst = 0; rst4 = 0; rst0 = 0;

        // Main instance: two-word image
        for (int i = 0; i < 8; i++) send(0, img[i], i == 7);
        check("load1_ld_ready_low", 32'(bus.ld_ready), 32'd0);
        check("load1_hart_rst_hold", 32'(bus.hart_rst), 32'd1);
        tick();
        check("load1_hart_rst_fall", 32'(bus.hart_rst), 32'd0);
        bus.pc = 32'h0; #1;
        check("load1_word0", bus.instruction, 32'h0000_0013);
        bus.pc = 32'h4; #1;
        check("load1_word1", bus.instruction, 32'h0010_0093);
        check("load1_fault", 32'(bus.fault), 32'd0);

        // Reset, partial word reload with a store attempted during LOAD
        rst = 1; #1;
        check("rst_async_ld_ready", 32'(bus.ld_ready), 32'd1);
        check("rst_async_hart_rst", 32'(bus.hart_rst), 32'd1);
        tick();
        rst = 0;
        bus.mem_write = 1; bus.mem_addr = 32'h4; bus.mem_data = 32'hFFFF_FFFF;
        send(0, 8'hAA, 0);
        send(0, 8'hBB, 0);
        send(0, 8'hCC, 1);
        bus.mem_write = 0;
        check("load2_ld_ready_low", 32'(bus.ld_ready), 32'd0);
        tick();
        bus.pc = 32'h0; #1;
        check("load2_partial_word", bus.instruction, 32'h00CC_BBAA);
        bus.pc = 32'h4; #1;
        check("load2_store_ignored", bus.instruction, 32'h0010_0093);
        check("load2_no_fault", 32'(bus.fault), 32'd0);

        // Run-time vector table
        for (int i = 0; i < 11; i++) begin
            bus.pc = vecs[i].pc; bus.mem_addr = vecs[i].addr;
            bus.mem_data = vecs[i].data; bus.mem_write = vecs[i].wr;
            #1;
            check($sformatf("vec%0d_instr", i), bus.instruction, vecs[i].exp_instr);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_read", i), bus.mem_read, vecs[i].exp_rd);
            check($sformatf("vec%0d_fault", i), 32'(bus.fault), 32'(vecs[i].exp_fault));
            tick();
            bus.mem_write = 0;
        end

        // DEPTH=4: reset after 6 bytes, then overflow by one byte
        for (int i = 1; i <= 6; i++) send(4, 8'(i), 0);
        rst4 = 1; #1;
        check("d4_rst_ld_ready", 32'(bus4.ld_ready), 32'd1);
        tick();
        rst4 = 0;
        for (int i = 0; i < 17; i++) begin
            if (i == 16) begin
                check("d4_full_still_load", 32'(bus4.ld_ready), 32'd1);
                check("d4_full_no_fault", 32'(bus4.fault), 32'd0);
            end
            send(4, 8'(8'h10 + i), 0);
        end
        check("d4_overflow_fault", 32'(bus4.fault), 32'd1);
        check("d4_overflow_run", 32'(bus4.ld_ready), 32'd0);
        tick();
        check("d4_hart_rst_fall", 32'(bus4.hart_rst), 32'd0);
        for (int w = 0; w < 4; w++) begin
            logic [31:0] exp;
            exp = {8'(8'h13 + 4*w), 8'(8'h12 + 4*w), 8'(8'h11 + 4*w), 8'(8'h10 + 4*w)};
            bus4.pc = 32'(4 * w); #1;
            check($sformatf("d4_word%0d", w), bus4.instruction, exp);
        end
        bus4.pc = 32'h10; #1;
        check("d4_pc_out_of_range", bus4.instruction, 32'h0000_0013);

        // No-loader instance: already running, loader ignored, stores work
        check("d0_hart_rst_low", 32'(bus0.hart_rst), 32'd0);
        send(1, 8'h55, 1);
        check("d0_loader_ignored", 32'(bus0.fault), 32'd0);
        bus0.mem_write = 1; bus0.mem_addr = 32'h8; bus0.mem_data = 32'h0000_0077;
        tick();
        bus0.mem_write = 0; #1;
        check("d0_store_read", bus0.mem_read, 32'h0000_0077);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
